// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stages.
//   XLEN_DEF / REG_AW_DEF : default datapath and register-address widths
//   skid_state_e          : occupancy of a two-entry skid stage, encoded as
//                           {skid_valid, main_valid}
package pipe_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } skid_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rstn : clock, async active-low reset (clears count)
//   inc       : add one this cycle unless already at all-ones
//   cnt       : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a two-entry skid buffer.
//   clk, rstn        : clock, async active-low reset
//   flush            : synchronous squash of both entries (data kept)
//   in_*             : payload from the MEM stage, valid/ready handshake
//   out_*            : head entry towards the register-file write port;
//                      out_wb_data selects load data or ALU result
//   stall_cnt        : saturating count of back-pressured cycles
// in_ready is a flop output (!skid_valid), so out_ready never reaches it
// combinationally; the skid entry absorbs the one payload launched while
// in_ready is still high.
module memwb_skid_stage
   import pipe_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic [REG_AW-1:0] in_dest,
   input  logic [XLEN-1:0]   in_alu_res,
   input  logic [XLEN-1:0]   in_mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic [REG_AW-1:0] out_dest,
   output logic [XLEN-1:0]   out_wb_data,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [REG_AW-1:0] dest;
      logic [XLEN-1:0]   alu_res;
      logic [XLEN-1:0]   mem_rdata;
   } payload_t;

   payload_t    main_q, main_d, skid_q, skid_d, cap;
   logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic        acc, fire;
   skid_state_e state;

   assign state = skid_state_e'({skid_vld_q, main_vld_q});

   assign in_ready = !skid_vld_q;
   assign acc      = in_valid && in_ready;
   assign fire     = main_vld_q && out_ready;

   // Writes to x0 are dropped here so the write port never sees them.
   always_comb begin
      cap           = '0;
      cap.wb_en     = in_wb_en && (in_dest != '0);
      cap.mem_r_en  = in_mem_r_en;
      cap.dest      = in_dest;
      cap.alu_res   = in_alu_res;
      cap.mem_rdata = in_mem_rdata;
   end

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         case (state)
            EMPTY: if (acc) begin
               main_d     = cap;
               main_vld_d = 1'b1;
            end
            ONE: begin
               if (acc && fire) main_d = cap;
               else if (acc) begin
                  skid_d     = cap;
                  skid_vld_d = 1'b1;
               end else if (fire) main_vld_d = 1'b0;
            end
            FULL: if (fire) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid   = main_vld_q;
   assign out_wb_en   = main_vld_q && main_q.wb_en;
   assign out_dest    = main_q.dest;
   assign out_wb_data = main_q.mem_r_en ? main_q.mem_rdata : main_q.alu_res;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (main_vld_q && !out_ready && !flush),
      .cnt  (stall_cnt)
   );

   // The skid entry is only ever filled behind a valid main entry.
   a_state_legal: assert property (@(posedge clk) disable iff (!rstn)
      state inside {EMPTY, ONE, FULL});
endmodule
